dcache_req_scheduler: RTL and testbench
=======================================

DCACHE_REQ_SCHEDULER -- requirements
Module: dcache_req_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, request address width.
REQ-002 SHALL have parameter ID_WIDTH, default 16, AXI transaction ID width.
REQ-003 SHALL have parameter INDEX_WIDTH, default 4, cache set index width, taken from addr[INDEX_WIDTH-1:0].
REQ-004 SHALL have parameter MAX_OUTST, default 4, number of outstanding-request slots; SLOT_W = $clog2(MAX_OUTST).
REQ-005 SHALL have ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- fifo_empty_i  in  1  request FIFO empty
- fifo_rdata_i  in  ADDR_WIDTH+ID_WIDTH+1  {rw, id, addr}; rw=1 write
- fifo_rden_o  out  1  FIFO pop strobe
- issue_valid_o  out  1  request valid to the cache pipeline
- issue_ready_i  in  1  cache pipeline accepts
- issue_rw_o  out  1  0 read, 1 write
- issue_id_o  out  ID_WIDTH  transaction ID
- issue_addr_o  out  ADDR_WIDTH  full address
- issue_slot_o  out  SLOT_W  allocated slot tag
- done_valid_i  in  1  pipeline completion strobe
- done_slot_i  in  SLOT_W  completed slot tag
- busy_o  out  1  scheduler or any slot active

Function
REQ-006 SHALL implement FSM states S_IDLE, S_FETCH, S_CHECK, S_ISSUE.
REQ-007 In S_IDLE, fifo_rden_o SHALL be driven combinationally high iff !fifo_empty_i, and the FSM SHALL go to S_FETCH in the same cycle; otherwise it SHALL stay in S_IDLE.
REQ-008 FIFO read latency is 1: in S_FETCH, fifo_rdata_i SHALL be latched into an internal request register, then the FSM SHALL go to S_CHECK.
REQ-009 S_CHECK SHALL detect a hazard when any occupied slot's stored index equals the latched addr[INDEX_WIDTH-1:0].
REQ-010 S_CHECK SHALL go to S_ISSUE only if there is no hazard and at least one slot is free; otherwise it SHALL stay in S_CHECK.
REQ-011 S_CHECK SHALL evaluate hazard and free-slot conditions from registered slot state only; a retire is visible on the cycle after done_valid_i.
REQ-012 On the S_CHECK->S_ISSUE transition, the lowest-numbered free slot SHALL be registered as issue_slot_o.
REQ-013 issue_valid_o SHALL be high iff state==S_ISSUE.
REQ-014 issue_rw_o/id_o/addr_o/slot_o SHALL hold stable while issue_valid_o is high and issue_ready_i is low.
REQ-015 On handshake (issue_valid_o && issue_ready_i), the allocated slot SHALL be marked occupied with its index stored, and the FSM SHALL return to S_IDLE.
REQ-016 Minimum latency SHALL be 3 cycles from the S_IDLE cycle with !fifo_empty_i to issue_valid_o high; the sustained rate is at most one request per 4 cycles.
REQ-017 done_valid_i SHALL clear the slot at done_slot_i; a done for an unoccupied slot SHALL be ignored without error.
REQ-018 A retire and an allocation in the same cycle (different slots) SHALL both take effect.
REQ-019 fifo_rden_o SHALL never be high outside S_IDLE; at most one request is held internally.
REQ-020 busy_o SHALL be high iff state!=S_IDLE or any slot is occupied.
REQ-021 Reads and writes SHALL be treated identically for hazard and slot purposes.

Reset
REQ-022 While rst_n is low at a clk edge: state=S_IDLE, all slots free, request register cleared.
REQ-023 Output values during reset: fifo_rden_o=0, issue_valid_o=0, issue_rw_o/id_o/addr_o/slot_o=0, busy_o=0.
REQ-024 Reset mid-operation (S_CHECK/S_ISSUE) SHALL drop the held request and all outstanding slots, with no issue afterwards.

Configuration
REQ-025 With macro DCACHE_SCHED_PERF_CNT_EN defined, the block SHALL add outputs perf_issue_cnt_o[31:0] and perf_stall_cnt_o[31:0].
- perf_issue_cnt_o increments per issue handshake.
- perf_stall_cnt_o increments per cycle spent in S_CHECK without advancing.
- Both counters reset to 0 and wrap at 2^32.
REQ-026 Without DCACHE_SCHED_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-027 Single read: FIFO entry {0,16'h0005,64'h1003}, issue_ready_i=1 -> fifo_rden_o pulse 1 cycle, issue_valid_o 3 cycles later with id=5, addr=0x1003, slot=0; busy_o=1 until done_slot_i=0.
REQ-028 Hazard: issue addr 0x13 (slot 0 outstanding), then addr 0x23 -> second request held in S_CHECK; issued with slot 0 the cycle after next following done_valid_i with done_slot_i=0.
REQ-029 Slots full: 4 requests with indices 0..3, no done -> 5th (index 4) stalls; done_slot_i=2 -> 5th issues with slot 2.
REQ-030 Backpressure: issue_ready_i=0 for 5 cycles -> issue_valid_o and payload stable for 5 cycles, no fifo_rden_o; accepted on the 6th cycle.
REQ-031 Spurious done on a free slot 3 plus a same-cycle allocation of slot 0 -> slot 0 occupied, slot 3 still free, no other state change.
REQ-032 Reset asserted in S_ISSUE with 2 slots busy -> all outputs 0 on the next cycle; with DCACHE_SCHED_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/dcache_req_scheduler.sv
// rtl/dcache_req_scheduler.sv - in-order D-cache request scheduler with set-index hazard and slot tracking
// Optional performance counters: DCACHE_SCHED_PERF_CNT_EN
module dcache_req_scheduler #(
  parameter int ADDR_WIDTH  = 64,
  parameter int ID_WIDTH    = 16,
  parameter int INDEX_WIDTH = 4,
  parameter int MAX_OUTST   = 4,
  localparam int SLOT_W     = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            fifo_empty_i,
  input  logic [ADDR_WIDTH+ID_WIDTH:0]    fifo_rdata_i,
  output logic                            fifo_rden_o,
  output logic                            issue_valid_o,
  input  logic                            issue_ready_i,
  output logic                            issue_rw_o,
  output logic [ID_WIDTH-1:0]             issue_id_o,
  output logic [ADDR_WIDTH-1:0]           issue_addr_o,
  output logic [SLOT_W-1:0]               issue_slot_o,
  input  logic                            done_valid_i,
  input  logic [SLOT_W-1:0]               done_slot_i,
`ifdef DCACHE_SCHED_PERF_CNT_EN
  output logic [31:0]                     perf_issue_cnt_o,
  output logic [31:0]                     perf_stall_cnt_o,
`endif
  output logic                            busy_o
);

  localparam int REQ_W = ADDR_WIDTH + ID_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CHECK, S_ISSUE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [REQ_W-1:0]       req_q;
  logic [SLOT_W-1:0]      slot_q;
  logic [MAX_OUTST-1:0]   slot_occ;
  logic [INDEX_WIDTH-1:0] slot_idx [MAX_OUTST];
  logic [INDEX_WIDTH-1:0] req_index;
  logic                   hazard;
  logic                   has_free;
  logic [SLOT_W-1:0]      free_slot;
  logic                   check_go;
  logic                   handshake;
  logic                   done_in_range;

  assign req_index     = req_q[INDEX_WIDTH-1:0];
  assign done_in_range = int'(done_slot_i) < MAX_OUTST;

  // Hazard and free-slot search look only at registered slot state; descending scan leaves the lowest free slot.
  always_comb begin
    hazard    = 1'b0;
    has_free  = 1'b0;
    free_slot = '0;
    for (int i = MAX_OUTST - 1; i >= 0; i--) begin
      if (slot_occ[i] && (slot_idx[i] == req_index)) begin
        hazard = 1'b1;
      end
      if (!slot_occ[i]) begin
        has_free  = 1'b1;
        free_slot = SLOT_W'(i);
      end
    end
  end

  assign check_go  = (state == S_CHECK) && !hazard && has_free;
  assign handshake = (state == S_ISSUE) && issue_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!fifo_empty_i) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_CHECK;
      S_CHECK: if (check_go) state_nxt = S_ISSUE;
      S_ISSUE: if (issue_ready_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The pop strobe is gated by reset so the FIFO is never drained while the block is held.
  always_comb begin
    fifo_rden_o   = rst_n && (state == S_IDLE) && !fifo_empty_i;
    issue_valid_o = (state == S_ISSUE);
    busy_o        = (state != S_IDLE) || (|slot_occ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q  <= '0;
      slot_q <= '0;
    end else begin
      if (state == S_FETCH) begin
        req_q <= fifo_rdata_i;
      end
      if (check_go) begin
        slot_q <= free_slot;
      end
    end
  end

  // Retire first, allocate second: the allocated slot was free, so a same-slot done is spurious.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_occ <= '0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        slot_idx[i] <= '0;
      end
    end else begin
      if (done_valid_i && done_in_range) begin
        slot_occ[done_slot_i] <= 1'b0;
      end
      if (handshake) begin
        slot_occ[slot_q] <= 1'b1;
        slot_idx[slot_q] <= req_index;
      end
    end
  end

  assign issue_rw_o   = req_q[REQ_W-1];
  assign issue_id_o   = req_q[ADDR_WIDTH +: ID_WIDTH];
  assign issue_addr_o = req_q[ADDR_WIDTH-1:0];
  assign issue_slot_o = slot_q;

`ifdef DCACHE_SCHED_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issue_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (handshake) begin
        perf_issue_cnt_o <= perf_issue_cnt_o + 32'd1;
      end
      if ((state == S_CHECK) && !check_go) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_req_scheduler.sv
// tb/tb_dcache_req_scheduler.sv - self-checking bench for dcache_req_scheduler
// Directed scenarios plus a randomized run against a transaction-level slot/hazard model.
module tb_dcache_req_scheduler;

  localparam int AW  = 64;
  localparam int IDW = 16;
  localparam int IXW = 4;
  localparam int MO  = 4;
  localparam int SW  = 2;
  localparam int EW  = AW + IDW + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           fifo_empty = 1'b1;
  logic [EW-1:0]  fifo_rdata = '0;
  logic           issue_ready = 1'b0;
  logic           done_valid = 1'b0;
  logic [SW-1:0]  done_slot = '0;
  logic           fifo_rden_o;
  logic           issue_valid_o;
  logic           issue_rw_o;
  logic [IDW-1:0] issue_id_o;
  logic [AW-1:0]  issue_addr_o;
  logic [SW-1:0]  issue_slot_o;
  logic           busy_o;
`ifdef DCACHE_SCHED_PERF_CNT_EN
  logic [31:0]    perf_issue_cnt_o;
  logic [31:0]    perf_stall_cnt_o;
`endif

  int            total = 0;
  int            bad = 0;
  logic          last_popped = 1'b0;
  logic [EW-1:0] fifo_q [$];

  dcache_req_scheduler #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .INDEX_WIDTH(IXW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_empty_i(fifo_empty), .fifo_rdata_i(fifo_rdata), .fifo_rden_o(fifo_rden_o),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready), .issue_rw_o(issue_rw_o),
    .issue_id_o(issue_id_o), .issue_addr_o(issue_addr_o), .issue_slot_o(issue_slot_o),
    .done_valid_i(done_valid), .done_slot_i(done_slot),
`ifdef DCACHE_SCHED_PERF_CNT_EN
    .perf_issue_cnt_o(perf_issue_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [EW-1:0] mk(input logic rw, input logic [IDW-1:0] id, input logic [AW-1:0] addr);
    return {rw, id, addr};
  endfunction

  // One clock with a 1-cycle-latency FIFO model; returns 2 time units after the edge.
  task automatic tick();
    logic pop;
    @(negedge clk);
    pop = fifo_rden_o;
    @(posedge clk);
    #1;
    last_popped = pop;
    if (pop && fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    #1;
  endtask

  task automatic push(input logic [EW-1:0] e);
    fifo_q.push_back(e);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    issue_ready = 1'b0;
    done_valid = 1'b0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_one(input logic [EW-1:0] e, output int slot, output bit ok);
    issue_ready = 1'b1;
    push(e);
    ok = 1'b0;
    slot = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (issue_valid_o) begin
        ok = 1'b1;
        slot = int'(issue_slot_o);
      end else begin
        tick();
      end
    end
    if (ok) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    issue_ready = 1'b1;
    fifo_empty = 1'b0;
    fifo_rdata = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (fifo_rden_o !== 1'b0) begin bad++; $display("FAIL reset_rden got %b exp 0", fifo_rden_o); end
    total++; if (issue_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", issue_valid_o); end
    total++;
    if ({issue_rw_o, issue_id_o, issue_addr_o, issue_slot_o} !== '0) begin
      bad++; $display("FAIL reset_payload got %h exp 0", {issue_rw_o, issue_id_o, issue_addr_o, issue_slot_o});
    end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    rst_n = 1'b1;
    tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_single_read();
    do_reset();
    issue_ready = 1'b1;
    push(mk(1'b0, 16'h0005, 64'h1003));
    #1;
    total++; if (fifo_rden_o !== 1'b1) begin bad++; $display("FAIL single_rden got %b exp 1", fifo_rden_o); end
    tick();
    total++;
    if (fifo_rden_o !== 1'b0 || issue_valid_o !== 1'b0) begin
      bad++; $display("FAIL single_fetch got rden=%b valid=%b exp 0 0", fifo_rden_o, issue_valid_o);
    end
    tick();
    total++; if (issue_valid_o !== 1'b0) begin bad++; $display("FAIL single_check got %b exp 0", issue_valid_o); end
    tick();
    total++;
    if (issue_valid_o !== 1'b1 || issue_id_o !== 16'h0005 || issue_addr_o !== 64'h1003 ||
        issue_slot_o !== 2'd0 || issue_rw_o !== 1'b0) begin
      bad++; $display("FAIL single_issue got v=%b id=%h addr=%h slot=%0d rw=%b exp 1 0005 1003 0 0",
                      issue_valid_o, issue_id_o, issue_addr_o, issue_slot_o, issue_rw_o);
    end
    tick();
    total++;
    if (issue_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL single_after got valid=%b busy=%b exp 0 1", issue_valid_o, busy_o);
    end
    repeat (3) tick();
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL single_busy_hold got %b exp 1", busy_o); end
    done_valid = 1'b1;
    done_slot = 2'd0;
    tick();
    done_valid = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_retire got %b exp 0", busy_o); end
  endtask

  task automatic test_hazard();
    int s;
    bit ok;
    do_reset();
    run_one(mk(1'b0, 16'h1, 64'h13), s, ok);
    total++; if (!ok || s != 0) begin bad++; $display("FAIL hazard_first got ok=%0d slot=%0d exp 1 0", ok, s); end
    push(mk(1'b1, 16'h2, 64'h23));
    repeat (6) tick();
    total++;
    if (issue_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL hazard_hold got valid=%b busy=%b exp 0 1", issue_valid_o, busy_o);
    end
    done_valid = 1'b1;
    done_slot = 2'd0;
    tick();
    done_valid = 1'b0;
    total++; if (issue_valid_o !== 1'b0) begin bad++; $display("FAIL hazard_early got %b exp 0", issue_valid_o); end
    tick();
    total++;
    if (issue_valid_o !== 1'b1 || issue_slot_o !== 2'd0 || issue_addr_o !== 64'h23 || issue_rw_o !== 1'b1) begin
      bad++; $display("FAIL hazard_issue got v=%b slot=%0d addr=%h rw=%b exp 1 0 23 1",
                      issue_valid_o, issue_slot_o, issue_addr_o, issue_rw_o);
    end
    tick();
  endtask

  task automatic test_slots_full();
    int s;
    bit ok;
    do_reset();
    for (int i = 0; i < MO; i++) begin
      run_one(mk(1'b0, IDW'(i), AW'(i)), s, ok);
      total++; if (!ok || s != i) begin bad++; $display("FAIL full_alloc%0d got ok=%0d slot=%0d exp 1 %0d", i, ok, s, i); end
    end
    push(mk(1'b0, 16'h44, 64'h4));
    repeat (6) tick();
    total++; if (issue_valid_o !== 1'b0) begin bad++; $display("FAIL full_stall got %b exp 0", issue_valid_o); end
    done_valid = 1'b1;
    done_slot = 2'd2;
    tick();
    done_valid = 1'b0;
    tick();
    total++;
    if (issue_valid_o !== 1'b1 || issue_slot_o !== 2'd2 || issue_addr_o !== 64'h4) begin
      bad++; $display("FAIL full_issue got v=%b slot=%0d addr=%h exp 1 2 4", issue_valid_o, issue_slot_o, issue_addr_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] e1;
    logic [EW-1:0] e2;
    int n;
    do_reset();
    e1 = mk(1'($urandom), IDW'($urandom), {$urandom, $urandom});
    e2 = mk(1'($urandom), IDW'($urandom), {$urandom, $urandom});
    push(e1);
    push(e2);
    n = 0;
    while (!issue_valid_o && n < 10) begin tick(); n++; end
    total++; if (n >= 10) begin bad++; $display("FAIL bp_timeout got no valid exp valid"); end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (issue_valid_o !== 1'b1 || {issue_rw_o, issue_id_o, issue_addr_o} !== e1 ||
          issue_slot_o !== 2'd0 || fifo_rden_o !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got v=%b pay=%h slot=%0d rden=%b exp 1 %h 0 0", c,
                        issue_valid_o, {issue_rw_o, issue_id_o, issue_addr_o}, issue_slot_o, fifo_rden_o, e1);
      end
      tick();
    end
    total++; if (issue_valid_o !== 1'b1) begin bad++; $display("FAIL bp_sixth got %b exp 1", issue_valid_o); end
    issue_ready = 1'b1;
    tick();
    total++;
    if (issue_valid_o !== 1'b0 || fifo_rden_o !== 1'b1) begin
      bad++; $display("FAIL bp_accept got valid=%b rden=%b exp 0 1", issue_valid_o, fifo_rden_o);
    end
  endtask

  task automatic test_spurious_done();
    int s;
    int n;
    bit ok;
    do_reset();
    issue_ready = 1'b1;
    push(mk(1'b0, 16'h7, 64'h5));
    n = 0;
    while (!issue_valid_o && n < 10) begin tick(); n++; end
    done_valid = 1'b1;
    done_slot = 2'd3;
    tick();
    done_valid = 1'b0;
    total++; if (n >= 10 || busy_o !== 1'b1) begin bad++; $display("FAIL spur_busy got n=%0d busy=%b exp <10 1", n, busy_o); end
    for (int i = 1; i < MO; i++) begin
      run_one(mk(1'b1, IDW'(i), AW'(i + 5)), s, ok);
      total++; if (!ok || s != i) begin bad++; $display("FAIL spur_alloc%0d got ok=%0d slot=%0d exp 1 %0d", i, ok, s, i); end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    int n;
    int vcount;
    bit ok;
    do_reset();
    run_one(mk(1'b0, 16'h11, 64'h1), s, ok);
    run_one(mk(1'b0, 16'h12, 64'h2), s, ok);
    total++; if (!ok || s != 1) begin bad++; $display("FAIL rmid_setup got ok=%0d slot=%0d exp 1 1", ok, s); end
    issue_ready = 1'b0;
    push(mk(1'b1, 16'hbeef, 64'hffff_0003));
    n = 0;
    while (!issue_valid_o && n < 10) begin tick(); n++; end
    total++; if (issue_valid_o !== 1'b1 || issue_slot_o !== 2'd2) begin
      bad++; $display("FAIL rmid_issue got v=%b slot=%0d exp 1 2", issue_valid_o, issue_slot_o);
    end
    push(mk(1'b0, 16'h14, 64'h4));
    rst_n = 1'b0;
    tick();
    total++;
    if (fifo_rden_o !== 1'b0 || issue_valid_o !== 1'b0 || busy_o !== 1'b0 ||
        {issue_rw_o, issue_id_o, issue_addr_o, issue_slot_o} !== '0) begin
      bad++; $display("FAIL rmid_outputs got rden=%b v=%b busy=%b pay=%h exp all 0", fifo_rden_o, issue_valid_o,
                      busy_o, {issue_rw_o, issue_id_o, issue_addr_o, issue_slot_o});
    end
`ifdef DCACHE_SCHED_PERF_CNT_EN
    total++;
    if (perf_issue_cnt_o !== 32'd0 || perf_stall_cnt_o !== 32'd0) begin
      bad++; $display("FAIL rmid_perf got %0d %0d exp 0 0", perf_issue_cnt_o, perf_stall_cnt_o);
    end
`endif
    fifo_q.delete();
    fifo_empty = 1'b1;
    rst_n = 1'b1;
    issue_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (issue_valid_o === 1'b1) vcount++;
    end
    total++; if (vcount != 0 || busy_o !== 1'b0) begin bad++; $display("FAIL rmid_quiet got valids=%0d busy=%b exp 0 0", vcount, busy_o); end
  endtask

  task automatic test_random();
    logic [EW-1:0]  exp_q [$];
    logic [MO-1:0]  occ;
    logic [MO-1:0]  occ_l;
    logic [IXW-1:0] idx [MO];
    logic [IXW-1:0] idx_l [MO];
    logic [EW-1:0]  held;
    logic [EW-1:0]  pay;
    logic [EW-1:0]  e;
    logic [SW-1:0]  hslot;
    logic [SW-1:0]  s;
    int inflight;
    int pushes;
    int lf;
    bit pv, phs, v, hs, haz, done_all;
    do_reset();
    occ = '0;
    occ_l = '0;
    for (int i = 0; i < MO; i++) begin idx[i] = '0; idx_l[i] = '0; end
    inflight = 0; pushes = 0; pv = 0; phs = 0; done_all = 0;
    held = '0; hslot = '0;
    for (int cyc = 0; cyc < 4000 && !done_all; cyc++) begin
      v = issue_valid_o;
      pay = {issue_rw_o, issue_id_o, issue_addr_o};
      s = issue_slot_o;
      total++;
      if (busy_o !== ((inflight > 0) || (|occ))) begin
        bad++; $display("FAIL rnd_busy cyc=%0d got %b exp %b", cyc, busy_o, (inflight > 0) || (|occ));
      end
      total++;
      if (fifo_rden_o !== ((inflight == 0) && (fifo_q.size() > 0))) begin
        bad++; $display("FAIL rnd_rden cyc=%0d got %b exp %b", cyc, fifo_rden_o, (inflight == 0) && (fifo_q.size() > 0));
      end
      if (v && (!pv || phs)) begin
        lf = -1;
        haz = 0;
        for (int i = MO - 1; i >= 0; i--) begin
          if (!occ_l[i]) lf = i;
          if (occ_l[i] && idx_l[i] == pay[IXW-1:0]) haz = 1;
        end
        total++;
        if (exp_q.size() == 0 || pay !== exp_q[0]) begin
          bad++; $display("FAIL rnd_order cyc=%0d got %h exp %h", cyc, pay, (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        total++; if (lf < 0 || s !== SW'(lf)) begin bad++; $display("FAIL rnd_slot cyc=%0d got %0d exp %0d", cyc, s, lf); end
        total++; if (haz) begin bad++; $display("FAIL rnd_hazard cyc=%0d got index %0d in flight exp none", cyc, pay[IXW-1:0]); end
      end else if (v) begin
        total++;
        if (pay !== held || s !== hslot) begin
          bad++; $display("FAIL rnd_stable cyc=%0d got %h/%0d exp %h/%0d", cyc, pay, s, held, hslot);
        end
      end
      issue_ready = ($urandom_range(0, 3) != 0);
      done_valid = ($urandom_range(0, 2) == 0);
      done_slot = SW'($urandom_range(0, MO - 1));
      hs = v && issue_ready;
      occ_l = occ;
      idx_l = idx;
      if (done_valid) occ[done_slot] = 1'b0;
      if (hs) begin
        occ[s] = 1'b1;
        idx[s] = pay[IXW-1:0];
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        inflight--;
      end
      pv = v; phs = hs; held = pay; hslot = s;
      if (pushes < 80 && $urandom_range(0, 2) == 0) begin
        e = mk(1'($urandom), IDW'($urandom), {$urandom, $urandom & 32'hffff_fff0} | AW'($urandom_range(0, 7)));
        push(e);
        exp_q.push_back(e);
        pushes++;
      end
      tick();
      if (last_popped) inflight++;
      done_all = (pushes == 80) && (exp_q.size() == 0) && (inflight == 0);
    end
    done_valid = 1'b0;
    total++; if (!done_all) begin bad++; $display("FAIL rnd_drain got pending=%0d exp 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_hazard();
    test_slots_full();
    test_backpressure();
    test_spurious_done();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
